// File: rtl/time_chain_counter.sv
// rtl/time_chain_counter.sv - cascaded modulo-N up/down counter forming one multi-field time value
//
// Purpose: chain of STAGES modulo counters (stage 0 least significant) that
// step together on en, rippling carry/borrow through every stage on a single
// edge. Supports per-stage range-checked loading for time setting, and either
// wraps or saturates when the top stage overflows.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset, clears all state
//   en        in   count tick, one step per cycle while high
//   dir       in   0 counts up, 1 counts down
//   load      in   synchronous load strobe (takes priority over en)
//   load_sel  in   index of the stage to load
//   load_val  in   value to load into the selected stage
//   count     out  packed stage values, stage i at count[W*i +: W]
//   rollover  out  one-cycle pulse when the chain wrapped or hit its limit
//   load_err  out  one-cycle pulse when a load was rejected

module time_chain_counter #(
  parameter int                  STAGES = 3,
  parameter int                  W      = 6,
  parameter logic [8*STAGES-1:0] MODS   = {8'd24, 8'd60, 8'd60},
  parameter bit                  WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [1:0]            load_sel,
  input  logic [W-1:0]          load_val,
  output logic [STAGES*W-1:0]   count,
  output logic                  rollover,
  output logic                  load_err
);

  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

  // Per-stage modulus in W+1 bits (so MOD = 2^W is representable) and the
  // stage maximum MOD-1, which always fits in W bits.
  logic [W:0]   mod_a   [STAGES];
  logic [W-1:0] mod_max [STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_mod
    localparam int           MOD_INT = int'(MODS[8*g +: 8]);
    localparam logic [W:0]   MOD_G   = (W+1)'(MOD_INT);
    localparam logic [W-1:0] MAX_G   = W'(MOD_INT - 1);
    assign mod_a[g]   = MOD_G;
    assign mod_max[g] = MAX_G;
  end

  logic [STAGES*W-1:0] count_q, count_d;
  logic                rollover_q, rollover_d;
  logic                load_err_q, load_err_d;

  logic         carry;
  logic         at_lim;
  logic         sel_ok;
  logic [W:0]   sel_mod;
  logic [W-1:0] cur;
  logic [W-1:0] nxt;

  always_comb begin
    count_d    = count_q;
    rollover_d = 1'b0;
    load_err_d = 1'b0;
    carry      = 1'b0;
    at_lim     = 1'b0;
    sel_mod    = '0;
    cur        = '0;
    nxt        = '0;

    // An out-of-range stage index leaves sel_mod at zero, so the range
    // check below rejects it without indexing past the modulus table.
    for (int i = 0; i < STAGES; i++) begin
      if (int'(load_sel) == i) begin
        sel_mod = mod_a[i];
      end
    end
    sel_ok = (int'(load_sel) < STAGES) && ({1'b0, load_val} < sel_mod);

    if (load) begin
      if (sel_ok) begin
        for (int i = 0; i < STAGES; i++) begin
          if (int'(load_sel) == i) begin
            count_d[W*i +: W] = load_val;
          end
        end
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      // carry doubles as borrow when counting down; it enters stage 0 set
      // and leaves the top stage set only if every stage was at its limit.
      carry = 1'b1;
      for (int i = 0; i < STAGES; i++) begin
        cur = count_q[W*i +: W];
        if (dir) begin
          at_lim = (cur == '0);
          nxt    = at_lim ? mod_max[i] : cur - ONE_W;
        end else begin
          at_lim = (cur == mod_max[i]);
          nxt    = at_lim ? '0 : cur + ONE_W;
        end
        if (carry) begin
          count_d[W*i +: W] = nxt;
        end
        carry = carry & at_lim;
      end
      if (carry) begin
        rollover_d = 1'b1;
        // Saturating mode: the chain is already at its extreme, so freeze it.
        if (!WRAP) begin
          count_d = count_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      rollover_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= rollover_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign rollover = rollover_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_time_chain_counter.sv
// tb/tb_time_chain_counter.sv - scoreboard bench for time_chain_counter (wrap, saturate, single-stage)

module tb_time_chain_counter;

  logic clk;
  logic reset;

  // Instance A: default parameters (wrapping h:m:s)
  logic        a_en, a_dir, a_load;
  logic [1:0]  a_sel;
  logic [5:0]  a_val;
  logic [17:0] a_cnt;
  logic        a_ro, a_le;

  // Instance B: saturating h:m:s
  logic        b_en, b_dir, b_load;
  logic [1:0]  b_sel;
  logic [5:0]  b_val;
  logic [17:0] b_cnt;
  logic        b_ro, b_le;

  // Instance C: single 4-bit stage, modulus 16
  logic        c_en, c_dir, c_load;
  logic [1:0]  c_sel;
  logic [3:0]  c_val;
  logic [3:0]  c_cnt;
  logic        c_ro, c_le;

  time_chain_counter u_a (
    .clk(clk), .reset(reset), .en(a_en), .dir(a_dir), .load(a_load),
    .load_sel(a_sel), .load_val(a_val), .count(a_cnt), .rollover(a_ro), .load_err(a_le)
  );

  time_chain_counter #(.WRAP(1'b0)) u_b (
    .clk(clk), .reset(reset), .en(b_en), .dir(b_dir), .load(b_load),
    .load_sel(b_sel), .load_val(b_val), .count(b_cnt), .rollover(b_ro), .load_err(b_le)
  );

  time_chain_counter #(.STAGES(1), .W(4), .MODS(8'd16), .WRAP(1'b1)) u_c (
    .clk(clk), .reset(reset), .en(c_en), .dir(c_dir), .load(c_load),
    .load_sel(c_sel), .load_val(c_val), .count(c_cnt), .rollover(c_ro), .load_err(c_le)
  );

  typedef struct {
    int          inst;
    logic [17:0] cnt;
    logic        ro;
    logic        le;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    logic [5:0] hh, mm, ss;
    hh = h[5:0];
    mm = m[5:0];
    ss = s[5:0];
    return {hh, mm, ss};
  endfunction

  task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    a_en = 0; a_dir = 0; a_load = 0; a_sel = 0; a_val = 0;
    b_en = 0; b_dir = 0; b_load = 0; b_sel = 0; b_val = 0;
    c_en = 0; c_dir = 0; c_load = 0; c_sel = 0; c_val = 0;
  endtask

  // Drives one cycle of stimulus on the chosen instance and queues the
  // state that instance must show after the next rising edge.
  task automatic step(input int inst, input logic e, input logic d, input logic l,
                      input logic [1:0] s, input logic [5:0] v,
                      input logic [17:0] ec, input logic ero, input logic ele,
                      input string nm);
    exp_t x;
    idle();
    case (inst)
      0: begin a_en = e; a_dir = d; a_load = l; a_sel = s; a_val = v; end
      1: begin b_en = e; b_dir = d; b_load = l; b_sel = s; b_val = v; end
      default: begin c_en = e; c_dir = d; c_load = l; c_sel = s; c_val = v[3:0]; end
    endcase
    x.inst = inst;
    x.cnt  = ec;
    x.ro   = ero;
    x.le   = ele;
    x.name = nm;
    sb.push_back(x);
  endtask

  // Monitor: one expectation is consumed per clock, sampled just after the edge.
  initial begin
    exp_t        x;
    logic [17:0] act_cnt;
    logic        act_ro, act_le;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        case (x.inst)
          0: begin act_cnt = a_cnt; act_ro = a_ro; act_le = a_le; end
          1: begin act_cnt = b_cnt; act_ro = b_ro; act_le = b_le; end
          default: begin act_cnt = {14'd0, c_cnt}; act_ro = c_ro; act_le = c_le; end
        endcase
        check({x.name, ".count"},    act_cnt,         x.cnt);
        check({x.name, ".rollover"}, {17'd0, act_ro}, {17'd0, x.ro});
        check({x.name, ".load_err"}, {17'd0, act_le}, {17'd0, x.le});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    a_en = 0; a_dir = 0; a_load = 0; a_sel = 0; a_val = 0;
    b_en = 0; b_dir = 0; b_load = 0; b_sel = 0; b_val = 0;
    c_en = 0; c_dir = 0; c_load = 0; c_sel = 0; c_val = 0;
    #12;
    check("reset.a_count",    a_cnt,          18'd0);
    check("reset.a_rollover", {17'd0, a_ro},  18'd0);
    check("reset.a_load_err", {17'd0, a_le},  18'd0);
    check("reset.b_count",    b_cnt,          18'd0);
    check("reset.c_count",    {14'd0, c_cnt}, 18'd0);
    @(negedge clk);
    reset = 1'b0;

    // Instance A: wrap in both directions, rejected loads, load-over-en.
    step(0, 0, 0, 1, 2'd0, 6'd59, hms(0, 0, 59),   0, 0, "a_ld_s59");
    step(0, 0, 0, 1, 2'd1, 6'd59, hms(0, 59, 59),  0, 0, "a_ld_m59");
    step(0, 0, 0, 1, 2'd2, 6'd23, hms(23, 59, 59), 0, 0, "a_ld_h23");
    step(0, 1, 0, 0, 2'd0, 6'd0,  hms(0, 0, 0),    1, 0, "a_up_wrap");
    step(0, 0, 0, 0, 2'd0, 6'd0,  hms(0, 0, 0),    0, 0, "a_idle1");
    step(0, 1, 1, 0, 2'd0, 6'd0,  hms(23, 59, 59), 1, 0, "a_dn_wrap");
    step(0, 1, 1, 0, 2'd0, 6'd0,  hms(23, 59, 58), 0, 0, "a_dn");
    step(0, 0, 0, 1, 2'd1, 6'd60, hms(23, 59, 58), 0, 1, "a_ld_m60");
    step(0, 0, 0, 0, 2'd0, 6'd0,  hms(23, 59, 58), 0, 0, "a_idle2");
    step(0, 0, 0, 1, 2'd3, 6'd60, hms(23, 59, 58), 0, 1, "a_ld_sel3");
    step(0, 0, 0, 1, 2'd2, 6'd24, hms(23, 59, 58), 0, 1, "a_ld_h24");
    step(0, 0, 0, 1, 2'd2, 6'd12, hms(12, 59, 58), 0, 0, "a_ld_h12");
    step(0, 0, 0, 1, 2'd1, 6'd34, hms(12, 34, 58), 0, 0, "a_ld_m34");
    step(0, 0, 0, 1, 2'd0, 6'd56, hms(12, 34, 56), 0, 0, "a_ld_s56");
    step(0, 1, 0, 1, 2'd1, 6'd7,  hms(12, 7, 56),  0, 0, "a_ld_en");
    step(0, 1, 0, 0, 2'd0, 6'd0,  hms(12, 7, 57),  0, 0, "a_up");
    step(0, 0, 0, 1, 2'd0, 6'd59, hms(12, 7, 59),  0, 0, "a_ld_s59b");
    step(0, 1, 0, 0, 2'd0, 6'd0,  hms(12, 8, 0),   0, 0, "a_up_carry");
    step(0, 1, 1, 0, 2'd0, 6'd0,  hms(12, 7, 59),  0, 0, "a_dn_borrow");
    step(0, 0, 0, 1, 2'd0, 6'd60, hms(12, 7, 59),  0, 1, "a_ld_s60");

    // Instance B: saturation at both ends.
    step(1, 0, 0, 1, 2'd0, 6'd58, hms(0, 0, 58),   0, 0, "b_ld_s58");
    step(1, 0, 0, 1, 2'd1, 6'd59, hms(0, 59, 58),  0, 0, "b_ld_m59");
    step(1, 0, 0, 1, 2'd2, 6'd23, hms(23, 59, 58), 0, 0, "b_ld_h23");
    step(1, 1, 0, 0, 2'd0, 6'd0,  hms(23, 59, 59), 0, 0, "b_up1");
    step(1, 1, 0, 0, 2'd0, 6'd0,  hms(23, 59, 59), 1, 0, "b_sat2");
    step(1, 1, 0, 0, 2'd0, 6'd0,  hms(23, 59, 59), 1, 0, "b_sat3");
    step(1, 0, 0, 0, 2'd0, 6'd0,  hms(23, 59, 59), 0, 0, "b_idle");
    step(1, 0, 0, 1, 2'd2, 6'd0,  hms(0, 59, 59),  0, 0, "b_ld_h0");
    step(1, 0, 0, 1, 2'd1, 6'd0,  hms(0, 0, 59),   0, 0, "b_ld_m0");
    step(1, 0, 0, 1, 2'd0, 6'd0,  hms(0, 0, 0),    0, 0, "b_ld_s0");
    step(1, 1, 1, 0, 2'd0, 6'd0,  hms(0, 0, 0),    1, 0, "b_sat_dn");
    step(1, 1, 0, 0, 2'd0, 6'd0,  hms(0, 0, 1),    0, 0, "b_up_after");

    // Instance C: modulus 2^W wraps after 16 steps.
    for (int k = 1; k <= 20; k++) begin
      step(2, 1, 0, 0, 2'd0, 6'd0, 18'(k % 16), (k == 16), 0, "c_up");
    end
    idle();
    @(posedge clk);
    #3;
    check("c_pre_reset.count", {14'd0, c_cnt}, 18'd4);

    // Asynchronous reset between edges.
    reset = 1'b1;
    #1;
    check("async_reset.c_count", {14'd0, c_cnt}, 18'd0);
    check("async_reset.a_count", a_cnt,          18'd0);
    check("async_reset.b_count", b_cnt,          18'd0);
    @(negedge clk);
    reset = 1'b0;

    step(2, 1, 0, 0, 2'd0, 6'd0,  18'd1,  0, 0, "c_resume");
    step(2, 0, 0, 1, 2'd1, 6'd3,  18'd1,  0, 1, "c_ld_sel1");
    step(2, 0, 0, 1, 2'd0, 6'd15, 18'd15, 0, 0, "c_ld_15");
    step(2, 1, 0, 0, 2'd0, 6'd0,  18'd0,  1, 0, "c_wrap");
    step(2, 1, 1, 0, 2'd0, 6'd0,  18'd15, 1, 0, "c_dn_wrap");
    idle();
    @(posedge clk);
    #3;
    check("sb_drained", 18'(sb.size()), 18'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
